link_parameter_loader: RTL and testbench
========================================

Name: link_parameter_loader

Overview:
- Transmitter end of the per-link parameter shift chain in the union-find decoder array.
- Accepts packed parameter words from the host/controller over a valid/ready stream.
- Unpacks each word into per-link {boundary_condition, weight} entries and shifts them into the link chain, one entry per cycle.
- Pulses done once exactly NUM_LINKS entries have been shifted. Integration maps chain_shift onto the links' parameter-loading enable.

Parameters:
- NUM_LINKS, 64, number of links in the chain (entries to shift per load).
- MAX_WEIGHT, 2, maximum legal link weight.
- LINK_BIT_WIDTH, $clog2(MAX_WEIGHT+1), weight field width (derived; do not override).
- IN_WIDTH, 32, host word width.
- ENTRY_WIDTH, LINK_BIT_WIDTH+2, packed entry width (derived).
- ENTRIES_PER_WORD, IN_WIDTH/ENTRY_WIDTH (floor), entries per host word (derived; must be ≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  begin a load; sampled only in IDLE.
- in_data  input  IN_WIDTH  packed entries; slot k at bits [k*ENTRY_WIDTH +: ENTRY_WIDTH]; entry = {bc[1:0], weight[LINK_BIT_WIDTH-1:0]}.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- chain_weight_out  output  LINK_BIT_WIDTH  weight presented to chain head.
- chain_boundary_out  output  2  boundary condition presented to chain head.
- chain_shift  output  1  chain captures the head entry at this clock edge.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the load completes.
- param_error  output  1  sticky: at least one weight was clamped during the current load.

Behaviour:
- Reset values: in_ready=0, chain_shift=0, chain_weight_out=0, chain_boundary_out=0, busy=0, done=0, param_error=0. Word buffer is invalid; all counters are 0.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: start=1 → RUN; clears param_error, shift counter, slot index and buffer-valid.
  - RUN: when shift count reaches NUM_LINKS → FINISH.
  - FINISH: done=1 for exactly one cycle, then → IDLE.
- busy=1 in RUN and FINISH.
- Handshake: transfer occurs when in_valid && in_ready. in_ready=1 only in RUN, and only when:
  - the buffer is invalid, or
  - the current slot is the last slot of the word (slot == ENTRIES_PER_WORD-1) and chain_shift=1 this cycle, and more than one entry remains to be shifted.
- Throughput: back-to-back words sustain one entry per cycle.
- Latency: a word accepted at edge t drives its first chain_shift in the cycle after t. No combinational path from in_* to chain_*, chain_shift, busy or done.
- Shifting:
  - chain_shift = (state==RUN) && buffer valid. It is held low while the buffer is empty, so the chain holds its contents.
  - chain_boundary_out = bc field of the current slot.
  - chain_weight_out = weight field of the current slot, clamped to MAX_WEIGHT.
  - Each shift increments slot and shift count. After the last slot, the buffer becomes invalid unless a new word is accepted in the same cycle (the new word loads with slot=0).
- Ordering: the first entry shifted lands in link NUM_LINKS-1 (farthest); the host sends entries farthest-first.
- Termination:
  - When shift count reaches NUM_LINKS, unused slots of the final word are discarded and the buffer is invalidated.
  - in_ready=0 from the final shift cycle onward.
  - Words beyond ceil(NUM_LINKS/ENTRIES_PER_WORD) are not accepted.
- Value checks:
  - A weight greater than MAX_WEIGHT is output as MAX_WEIGHT and sets param_error. param_error holds until the next start or reset.
  - bc=2 and bc=3 pass through unchanged (both mean a non-existent edge downstream).
- start during RUN or FINISH is ignored.
- reset mid-load: all state returns to reset values immediately at the reset edge; no chain_shift occurs in the reset cycle or the cycle after. A partially loaded chain is the controller's responsibility and requires a fresh start.
- Width rules: shift counter width $clog2(NUM_LINKS+1); slot index width $clog2(ENTRIES_PER_WORD) (minimum 1).

Test Plan:
- Nominal: NUM_LINKS=64, LINK_BIT_WIDTH=2, 8 back-to-back words, each entry {bc=0, weight=slot%3} → exactly 64 consecutive chain_shift cycles starting one cycle after the first accept. done pulses in the cycle after the 64th shift; in_ready rises exactly 8 times; param_error=0.
- Stalls: in_valid drops for 3 cycles between words 2 and 3 → chain_shift low for exactly those gap cycles. The entry sequence is unchanged and the total shift count is still 64.
- Partial last word: NUM_LINKS=10, 2 words sent → 10 shifts. Slots 2..7 of word 2 are never presented; a third word offered is never accepted (in_ready stays 0); done pulses once.
- Clamp: an entry with weight=3 and MAX_WEIGHT=2 → chain_weight_out=2 on that shift, and param_error=1 until the next start, which clears it.
- Boundary passthrough: bc values 1, 2, 3 in consecutive slots → chain_boundary_out shows 1, 2, 3 on consecutive shift cycles.
- Control robustness:
  - start pulsed during RUN → no restart and no count change.
  - reset asserted after 20 shifts → all outputs 0 next cycle; a new start then completes a full 64-shift load.

Source files
------------

// File: rtl/link_parameter_loader.sv
// Head of the per-link parameter shift chain: unpacks host words into
// {boundary, weight} entries and shifts exactly NUM_LINKS of them into the link chain.
module link_parameter_loader #(
    parameter int NUM_LINKS = 64,
    parameter int MAX_WEIGHT = 2,
    parameter int IN_WIDTH = 32,
    localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
    localparam int ENTRY_WIDTH = LINK_BIT_WIDTH + 2,
    localparam int ENTRIES_PER_WORD = IN_WIDTH / ENTRY_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LINK_BIT_WIDTH-1:0] chain_weight_out,
    output logic [1:0]                chain_boundary_out,
    output logic                      chain_shift,
    output logic                      busy,
    output logic                      done,
    output logic                      param_error
);

    localparam int CW = $clog2(NUM_LINKS + 1);
    localparam int SW = (ENTRIES_PER_WORD > 1) ? $clog2(ENTRIES_PER_WORD) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(ENTRIES_PER_WORD - 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_LINKS - 1);
    localparam logic [LINK_BIT_WIDTH-1:0] MAX_W = LINK_BIT_WIDTH'(MAX_WEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] buf_q, buf_d;
    logic                buf_valid_q, buf_valid_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;

    logic [ENTRY_WIDTH-1:0]    slots [ENTRIES_PER_WORD];
    logic [ENTRY_WIDTH-1:0]    cur_entry;
    logic [LINK_BIT_WIDTH-1:0] cur_weight;
    logic                      over_weight;
    logic                      shift;
    logic                      last_shift;
    logic                      accept;

    always_comb begin
        for (int k = 0; k < ENTRIES_PER_WORD; k++) begin
            slots[k] = buf_q[k*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
    end

    // Valid/ready: a word transfers on any edge where in_valid && in_ready; in_ready
    // never depends on in_valid, and in_data must be stable while in_valid is high.
    always_comb begin
        cur_entry   = slots[slot_q];
        cur_weight  = cur_entry[LINK_BIT_WIDTH-1:0];
        over_weight = cur_weight > MAX_W;
        shift       = (state_q == RUN) && buf_valid_q;
        last_shift  = shift && (count_q == LAST_COUNT);
        in_ready    = (state_q == RUN) &&
                      (!buf_valid_q || ((slot_q == LAST_SLOT) && shift && !last_shift));
        accept      = in_ready && in_valid;
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        slot_d      = slot_q;
        count_d     = count_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    buf_valid_d = 1'b0;
                    slot_d      = '0;
                    count_d     = '0;
                    err_d       = 1'b0;
                end
            end
            RUN: begin
                if (shift) begin
                    count_d = count_q + CW'(1);
                    if (over_weight) begin
                        err_d = 1'b1;
                    end
                    if (last_shift) begin
                        // Unused slots of the final word are dropped here.
                        state_d     = FINISH;
                        buf_valid_d = 1'b0;
                        slot_d      = '0;
                    end else if (slot_q == LAST_SLOT) begin
                        slot_d      = '0;
                        buf_valid_d = accept;
                        if (accept) begin
                            buf_d = in_data;
                        end
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end else if (accept) begin
                    buf_d       = in_data;
                    buf_valid_d = 1'b1;
                    slot_d      = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            slot_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            slot_q      <= slot_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // The head entry is forced to zero whenever the chain is not capturing.
    always_comb begin
        chain_shift        = shift;
        chain_weight_out   = shift ? (over_weight ? MAX_W : cur_weight) : '0;
        chain_boundary_out = shift ? cur_entry[ENTRY_WIDTH-1 -: 2] : 2'b00;
        busy               = (state_q != IDLE);
        done               = (state_q == FINISH);
        param_error        = err_q;
    end

endmodule

// File: tb/tb_link_parameter_loader.sv
// Bench for link_parameter_loader: a 64-link and a 10-link instance, driven by a
// word-level host and checked against a flattened-entry reference list.
module tb_link_parameter_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, sel;
    logic [31:0] in_data;

    logic       ready64, shift64, busy64, done64, err64;
    logic [1:0] w64, bc64;
    logic       ready10, shift10, busy10, done10, err10;
    logic [1:0] w10, bc10;

    logic       m_ready, m_shift, m_busy, m_done, m_err;
    logic [1:0] m_w, m_bc;

    always #5 clk = ~clk;

    link_parameter_loader #(.NUM_LINKS(64), .MAX_WEIGHT(2), .IN_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start && !sel), .in_data(in_data),
        .in_valid(in_valid && !sel), .in_ready(ready64), .chain_weight_out(w64),
        .chain_boundary_out(bc64), .chain_shift(shift64), .busy(busy64),
        .done(done64), .param_error(err64));

    link_parameter_loader #(.NUM_LINKS(10), .MAX_WEIGHT(2), .IN_WIDTH(32)) dut10 (
        .clk(clk), .reset(reset), .start(start && sel), .in_data(in_data),
        .in_valid(in_valid && sel), .in_ready(ready10), .chain_weight_out(w10),
        .chain_boundary_out(bc10), .chain_shift(shift10), .busy(busy10),
        .done(done10), .param_error(err10));

    assign m_ready = sel ? ready10 : ready64;
    assign m_shift = sel ? shift10 : shift64;
    assign m_busy  = sel ? busy10  : busy64;
    assign m_done  = sel ? done10  : done64;
    assign m_err   = sel ? err10   : err64;
    assign m_w     = sel ? w10     : w64;
    assign m_bc    = sel ? bc10    : bc64;

    typedef struct {
        logic [3:0] entry;
        logic [1:0] exp_bc;
        logic [1:0] exp_w;
    } vec_t;
    vec_t tbl [16];

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] words [$];
    logic [3:0]  got_q [$];
    int first_acc, first_shift, last_shift, done_cyc, n_acc, n_shift, n_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, {31'd0, m_ready}, 0);
        check({tag, "_shift"}, {31'd0, m_shift}, 0);
        check({tag, "_weight"}, {30'd0, m_w}, 0);
        check({tag, "_bc"}, {30'd0, m_bc}, 0);
        check({tag, "_busy"}, {31'd0, m_busy}, 0);
        check({tag, "_done"}, {31'd0, m_done}, 0);
        check({tag, "_err"}, {31'd0, m_err}, 0);
    endtask

    // Host offers words[] in order; optional stall holds off a given word for
    // stall_len cycles in which the loader is ready; abort_at>0 raises reset.
    task automatic run_load(input int stall_word, input int stall_len, input bit rand_valid,
                            input int mid_start, input int abort_at);
        int w = 0;
        int stall_left = stall_len;
        got_q.delete();
        first_acc = -1; first_shift = -1; last_shift = -1; done_cyc = -1;
        n_acc = 0; n_shift = 0; n_done = 0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            start = (c == mid_start);
            if (abort_at > 0 && n_shift == abort_at) begin
                reset = 1'b1;
                in_valid = 1'b0;
                break;
            end
            in_valid = 1'b0;
            in_data = $urandom;
            if (w < words.size()) begin
                in_data = words[w];
                in_valid = 1'b1;
                if (rand_valid && $urandom_range(0, 3) == 0) in_valid = 1'b0;
                if (w == stall_word && stall_left > 0 && m_ready) begin
                    in_valid = 1'b0;
                    stall_left--;
                end
            end
            @(negedge clk);
            if (c == 0) check("err_cleared_by_start", {31'd0, m_err}, 0);
            if (in_valid && m_ready) begin
                if (first_acc < 0) first_acc = c;
                n_acc++;
                w++;
            end
            if (m_shift) begin
                if (first_shift < 0) first_shift = c;
                last_shift = c;
                n_shift++;
                got_q.push_back({m_bc, m_w});
            end
            if (m_done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check("ready_low_in_finish", {31'd0, m_ready}, 0);
                    check("busy_in_finish", {31'd0, m_busy}, 1);
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check("done_one_cycle", {31'd0, m_done}, 0);
                check("busy_after_done", {31'd0, m_busy}, 0);
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    // Reference: the first nl entries of the flattened word list, weights clamped.
    task automatic verify(input int nl, input int exp_gap, input string tag);
        logic [31:0] wd;
        logic [3:0]  e;
        logic [1:0]  ew;
        logic        exp_err = 1'b0;
        check({tag, "_done_seen"}, {31'd0, done_cyc >= 0}, 1);
        check({tag, "_shift_count"}, n_shift, nl);
        check({tag, "_accepts"}, n_acc, (nl + 7) / 8);
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_first_shift_latency"}, first_shift - first_acc, 1);
        check({tag, "_done_after_last"}, done_cyc - last_shift, 1);
        if (exp_gap >= 0) check({tag, "_gap_cycles"}, last_shift - first_shift + 1 - nl, exp_gap);
        for (int i = 0; i < nl; i++) begin
            wd = words[i / 8];
            e = wd[(i % 8) * 4 +: 4];
            ew = (e[1:0] > 2'd2) ? 2'd2 : e[1:0];
            if (e[1:0] == 2'd3) exp_err = 1'b1;
            if (i < got_q.size()) begin
                check($sformatf("%s_entry%0d", tag, i), {28'd0, got_q[i]}, {28'd0, e[3:2], ew});
            end
        end
        check({tag, "_param_error"}, {31'd0, m_err}, {31'd0, exp_err});
    endtask

    task automatic fill_words(input int n, input int max_w);
        logic [31:0] wd;
        words.delete();
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < 8; s++) begin
                wd[s*4 +: 4] = {2'($urandom_range(0, 3)), 2'($urandom_range(0, max_w))};
            end
            words.push_back(wd);
        end
    endtask

    initial begin
        logic [31:0] wd;
        tbl[0]  = '{4'b00_00, 2'd0, 2'd0};
        tbl[1]  = '{4'b00_01, 2'd0, 2'd1};
        tbl[2]  = '{4'b00_10, 2'd0, 2'd2};
        tbl[3]  = '{4'b00_11, 2'd0, 2'd2};
        tbl[4]  = '{4'b01_00, 2'd1, 2'd0};
        tbl[5]  = '{4'b10_01, 2'd2, 2'd1};
        tbl[6]  = '{4'b11_10, 2'd3, 2'd2};
        tbl[7]  = '{4'b01_11, 2'd1, 2'd2};
        tbl[8]  = '{4'b10_11, 2'd2, 2'd2};
        tbl[9]  = '{4'b11_11, 2'd3, 2'd2};
        tbl[10] = '{4'b11_00, 2'd3, 2'd0};
        tbl[11] = '{4'b10_10, 2'd2, 2'd2};
        tbl[12] = '{4'b01_01, 2'd1, 2'd1};
        tbl[13] = '{4'b00_11, 2'd0, 2'd2};
        tbl[14] = '{4'b10_00, 2'd2, 2'd0};
        tbl[15] = '{4'b01_10, 2'd1, 2'd2};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset64");
        sel = 1'b1; #1;
        check_idle_zero("reset10");
        sel = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Nominal: entries {bc=0, weight=slot%3}, back to back.
        words.delete();
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) wd[s*4 +: 4] = {2'b00, 2'(s % 3)};
            words.push_back(wd);
        end
        run_load(-1, 0, 1'b0, -1, 0);
        verify(64, 0, "nominal");

        // Three-cycle host stall before word 3, plus a start pulse mid-run.
        fill_words(9, 2);
        run_load(2, 3, 1'b0, 10, 0);
        verify(64, 3, "stall");

        // Table vectors: clamp and boundary passthrough in known slots.
        fill_words(8, 2);
        for (int i = 0; i < 16; i++) begin
            wd = words[i / 8];
            wd[(i % 8) * 4 +: 4] = tbl[i].entry;
            words[i / 8] = wd;
        end
        run_load(-1, 0, 1'b0, -1, 0);
        verify(64, 0, "table");
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("tbl%0d_bc", i), {30'd0, got_q[i][3:2]}, {30'd0, tbl[i].exp_bc});
                check($sformatf("tbl%0d_w", i), {30'd0, got_q[i][1:0]}, {30'd0, tbl[i].exp_w});
            end
        end
        repeat (3) @(negedge clk);
        check("param_error_held_idle", {31'd0, m_err}, 1);

        // Partial last word on the 10-link instance; a third word is offered.
        sel = 1'b1;
        fill_words(3, 3);
        run_load(-1, 0, 1'b0, -1, 0);
        verify(10, 0, "partial");
        sel = 1'b0;

        // Random valid gaps with occasional over-range weights.
        for (int r = 0; r < 3; r++) begin
            fill_words(9, 3);
            run_load(-1, 0, 1'b1, -1, 0);
            verify(64, -1, $sformatf("rand%0d", r));
        end

        // Reset after 20 shifts, then a complete fresh load.
        fill_words(8, 2);
        run_load(-1, 0, 1'b0, -1, 20);
        check("abort_reached", n_shift, 20);
        @(posedge clk); #1;
        check_idle_zero("midreset");
        reset = 1'b0;
        @(posedge clk); #1;
        check("no_shift_after_reset", {31'd0, m_shift}, 0);
        check("idle_after_reset", {31'd0, m_busy}, 0);
        fill_words(8, 3);
        run_load(-1, 0, 1'b0, -1, 0);
        verify(64, 0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
